// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and helpers for the elastic pipeline stage register.
// Default control-bit positions are provided for instantiators packing a stage bundle.
package pipe_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

    localparam int unsigned MAX_STAGES = 4;
    localparam int unsigned OCC_W      = clog2(2 * MAX_STAGES + 1);

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_JAL      = 2;
    localparam int unsigned CTRL_MEMWRITE = 3;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One elastic register slot: either a skid-buffered pair (registered ready)
// or a plain enabled register (ready chained combinationally).
module pipe_slot #(
    parameter int unsigned W      = 32,
    parameter int unsigned CTRL_W = 8,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [W-1:0]      in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [W-1:0]      out_data_o
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [W-1:0]      main_data_q, main_data_d;
    logic              main_free;

    assign main_free   = !main_valid_q || out_ready_i;
    assign out_valid_o = main_valid_q;
    assign out_ctrl_o  = main_valid_q ? main_ctrl_q : '0;
    assign out_data_o  = main_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
        end
    end

    if (SKID) begin : g_skid
        logic              skid_valid_q, skid_valid_d;
        logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
        logic [W-1:0]      skid_data_q, skid_data_d;
        logic              ready_q, ready_d;
        logic              in_fire;

        assign in_ready_o = ready_q;
        assign in_fire    = in_valid_i && ready_q;

        always_comb begin
            main_valid_d = main_valid_q;
            main_ctrl_d  = main_ctrl_q;
            main_data_d  = main_data_q;
            skid_valid_d = skid_valid_q;
            skid_ctrl_d  = skid_ctrl_q;
            skid_data_d  = skid_data_q;
            if (flush_i) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end else if (skid_valid_q) begin
                // Skid drains first; ready stays low until it is empty.
                if (main_free) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = skid_ctrl_q;
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_ctrl_d  = '0;
                end
            end else if (in_fire) begin
                if (main_free) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = in_ctrl_i;
                    main_data_d  = in_data_i;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_ctrl_d  = in_ctrl_i;
                    skid_data_d  = in_data_i;
                end
            end else if (out_ready_i) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
            ready_d = !skid_valid_d;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                skid_valid_q <= 1'b0;
                skid_ctrl_q  <= '0;
                skid_data_q  <= '0;
                ready_q      <= 1'b1;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_ctrl_q  <= skid_ctrl_d;
                skid_data_q  <= skid_data_d;
                ready_q      <= ready_d;
            end
        end
    end else begin : g_plain
        assign in_ready_o = main_free;

        always_comb begin
            main_valid_d = main_valid_q;
            main_ctrl_d  = main_ctrl_q;
            main_data_d  = main_data_q;
            if (flush_i) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end else if (main_free) begin
                main_valid_d = in_valid_i;
                if (in_valid_i) begin
                    main_ctrl_d = in_ctrl_i;
                    main_data_d = in_data_i;
                end else begin
                    main_ctrl_d = '0;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: STAGES slots in series with hazard Stall/Flush,
// bubble-zeroed control bundle and a registered occupancy count.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned STAGES = 1,
    parameter bit          SKID   = 1'b1
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             InValid,
    output logic                             InReady,
    input  logic [CTRL_W-1:0]                InCtrl,
    input  logic [DATA_W-1:0]                InData,
    input  logic                             Stall,
    input  logic                             Flush,
    output logic                             OutValid,
    input  logic                             OutReady,
    output logic [CTRL_W-1:0]                OutCtrl,
    output logic [DATA_W-1:0]                OutData,
    output logic [$clog2(2*STAGES+1)-1:0]    Occupancy
);

    localparam int unsigned OccW = clog2(2 * STAGES + 1);

    logic [STAGES:0]             valid_c;
    logic [STAGES:0]             ready_c;
    logic [STAGES:0][CTRL_W-1:0] ctrl_c;
    logic [STAGES:0][DATA_W-1:0] data_c;
    logic                        accept_ok;
    logic                        in_fire;
    logic                        out_fire;
    logic [OccW-1:0]             occ_q, occ_d;

    // Rst > Flush > Stall all block acceptance at the input only.
    assign accept_ok  = !Rst && !Flush && !Stall;
    assign InReady    = ready_c[0] && accept_ok;
    assign valid_c[0] = InValid && accept_ok;
    assign ctrl_c[0]  = InCtrl;
    assign data_c[0]  = InData;
    assign ready_c[STAGES] = OutReady;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        pipe_slot #(
            .W      (DATA_W),
            .CTRL_W (CTRL_W),
            .SKID   (SKID)
        ) u_slot (
            .clk_i       (Clk),
            .rst_i       (Rst),
            .flush_i     (Flush),
            .in_valid_i  (valid_c[i]),
            .in_ready_o  (ready_c[i]),
            .in_ctrl_i   (ctrl_c[i]),
            .in_data_i   (data_c[i]),
            .out_valid_o (valid_c[i+1]),
            .out_ready_i (ready_c[i+1]),
            .out_ctrl_o  (ctrl_c[i+1]),
            .out_data_o  (data_c[i+1])
        );
    end

    assign OutValid = valid_c[STAGES];
    assign OutCtrl  = ctrl_c[STAGES] & {CTRL_W{OutValid}};
    assign OutData  = data_c[STAGES];

    assign in_fire  = InValid && InReady;
    assign out_fire = OutValid && OutReady;

    always_comb begin
        occ_d = occ_q;
        if (Flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OccW'(1);
        end else if (!in_fire && out_fire) begin
            occ_d = occ_q - OccW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign Occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid-buffered 2-stage instance (A) and
// a plain 1-stage instance (B), with per-instance scoreboard queues.
module tb_pipe_stage_reg;

    logic        Clk;
    logic        Rst;

    logic        a_in_valid, a_in_ready, a_stall, a_flush;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data, a_out_data;
    logic        a_out_valid, a_out_ready;
    logic [2:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_stall, b_flush;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [31:0] b_in_data, b_out_data;
    logic        b_out_valid, b_out_ready;
    logic [1:0]  b_occ;

    int n_tests;
    int n_fail;
    logic [39:0] qa[$];
    logic [39:0] qb[$];

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .STAGES(2), .SKID(1'b1)) u_dut_a (
        .Clk(Clk), .Rst(Rst), .InValid(a_in_valid), .InReady(a_in_ready),
        .InCtrl(a_in_ctrl), .InData(a_in_data), .Stall(a_stall), .Flush(a_flush),
        .OutValid(a_out_valid), .OutReady(a_out_ready), .OutCtrl(a_out_ctrl),
        .OutData(a_out_data), .Occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .STAGES(1), .SKID(1'b0)) u_dut_b (
        .Clk(Clk), .Rst(Rst), .InValid(b_in_valid), .InReady(b_in_ready),
        .InCtrl(b_in_ctrl), .InData(b_in_data), .Stall(b_stall), .Flush(b_flush),
        .OutValid(b_out_valid), .OutReady(b_out_ready), .OutCtrl(b_out_ctrl),
        .OutData(b_out_data), .Occupancy(b_occ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] ctrl_of(input logic [31:0] d);
        return d[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Samples handshakes mid-low-phase, then advances to the next falling edge.
    task automatic tick();
        logic [39:0] exp;
        #1;
        if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
            n_tests++;
            assert (qa.size() != 0) else begin
                n_fail++;
                $error("FAIL a_unexpected: observed beat 0x%0h expected none", a_out_data);
            end
            if (qa.size() != 0) begin
                exp = qa.pop_front();
                check("a_beat", {a_out_ctrl, a_out_data}, exp);
            end
        end
        if (a_in_valid === 1'b1 && a_in_ready === 1'b1) qa.push_back({a_in_ctrl, a_in_data});
        if (Rst || a_flush) qa.delete();
        if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            n_tests++;
            assert (qb.size() != 0) else begin
                n_fail++;
                $error("FAIL b_unexpected: observed beat 0x%0h expected none", b_out_data);
            end
            if (qb.size() != 0) begin
                exp = qb.pop_front();
                check("b_beat", {b_out_ctrl, b_out_data}, exp);
            end
        end
        if (b_in_valid === 1'b1 && b_in_ready === 1'b1) qb.push_back({b_in_ctrl, b_in_data});
        if (Rst || b_flush) qb.delete();
        @(negedge Clk);
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d);
        a_in_valid = v;
        a_in_data  = d;
        a_in_ctrl  = ctrl_of(d);
    endtask

    initial begin
        int acc;
        n_tests = 0;
        n_fail  = 0;

        // Reset with a beat presented
        Rst = 1'b1;
        a_stall = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        b_stall = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        drive_a(1'b1, 32'hDEADBEEF);
        b_in_valid = 1'b1; b_in_data = 32'hDEADBEEF; b_in_ctrl = 8'hFF;
        tick();
        check("rst_in_ready", a_in_ready, 1'b0);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_out_ctrl", a_out_ctrl, 8'h00);
        check("rst_out_data", a_out_data, 32'h0);
        check("rst_occ", a_occ, 3'd0);
        check("rst_b_out_valid", b_out_valid, 1'b0);
        tick();
        Rst = 1'b0;
        drive_a(1'b0, 32'h0);
        b_in_valid = 1'b0;
        #1;
        check("post_rst_a_ready", a_in_ready, 1'b1);
        check("post_rst_b_ready", b_in_ready, 1'b1);
        check("post_rst_occ", a_occ, 3'd0);

        // Streaming 0x1..0x8 with OutReady held high
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (cyc < 8) drive_a(1'b1, 32'(cyc + 1));
            else drive_a(1'b0, 32'h0);
            #1;
            if (cyc < 8) check("stream_ready", a_in_ready, 1'b1);
            if (cyc == 1) check("lat_early", a_out_valid, 1'b0);
            if (cyc == 2) check("lat_first", {a_out_valid, a_out_data}, {1'b1, 32'h1});
            if (cyc >= 2 && cyc <= 9) check("stream_contig", a_out_valid, 1'b1);
            tick();
        end
        check("stream_drained", qa.size(), 0);

        // Backpressure: capacity is two beats per slot
        a_out_ready = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive_a(1'b1, 32'h10 + 32'(acc));
            #1;
            if (a_in_ready) acc++;
            tick();
        end
        #1;
        check("bp_accepted", acc, 4);
        check("bp_occ", a_occ, 3'd4);
        check("bp_ready", a_in_ready, 1'b0);
        drive_a(1'b0, 32'h0);
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) tick();
        check("bp_drained", qa.size(), 0);
        check("bp_occ_empty", a_occ, 3'd0);

        // Stall: input blocked, held beats keep draining
        drive_a(1'b1, 32'h20);
        tick();
        drive_a(1'b1, 32'h21);
        tick();
        a_stall = 1'b1;
        drive_a(1'b1, 32'h55);
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            check("stall_ready", a_in_ready, 1'b0);
            if (cyc == 1) check("stall_drain", {a_out_valid, a_out_data}, {1'b1, 32'h21});
            if (cyc == 2) check("stall_occ", a_occ, 3'd0);
            tick();
        end
        a_stall = 1'b0;
        #1;
        check("stall_release", a_in_ready, 1'b1);
        tick();
        drive_a(1'b0, 32'h0);
        for (int cyc = 0; cyc < 3; cyc++) tick();
        check("stall_drained", qa.size(), 0);

        // Flush with three beats held
        a_out_ready = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            a_in_valid = 1'b1; a_in_data = 32'h30 + 32'(cyc); a_in_ctrl = 8'hFF;
            tick();
        end
        a_flush = 1'b1;
        a_in_valid = 1'b1; a_in_data = 32'h66; a_in_ctrl = 8'hFF;
        #1;
        check("flush_ready", a_in_ready, 1'b0);
        check("flush_pre_occ", a_occ, 3'd3);
        check("flush_pre_ctrl", a_out_ctrl, 8'hFF);
        tick();
        a_flush = 1'b0;
        drive_a(1'b0, 32'h0);
        #1;
        check("flush_valid", a_out_valid, 1'b0);
        check("flush_ctrl", a_out_ctrl, 8'h00);
        check("flush_occ", a_occ, 3'd0);
        check("flush_data_hold", a_out_data, 32'h30);
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) tick();
        check("flush_quiet", a_out_valid, 1'b0);

        // Reset mid-transfer discards held beats
        a_out_ready = 1'b0;
        drive_a(1'b1, 32'h70);
        tick();
        drive_a(1'b1, 32'h71);
        tick();
        drive_a(1'b0, 32'h0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        a_out_ready = 1'b1;
        #1;
        check("mid_rst_occ", a_occ, 3'd0);
        check("mid_rst_data", a_out_data, 32'h0);
        for (int cyc = 0; cyc < 4; cyc++) tick();
        check("mid_rst_quiet", a_out_valid, 1'b0);

        // SKID=0: ready mirrors OutReady once the single slot is full
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            b_in_valid  = 1'b1;
            b_in_data   = 32'h40 + 32'(acc);
            b_in_ctrl   = ctrl_of(b_in_data);
            b_out_ready = (k % 2 == 0);
            #1;
            if (k > 0) check("b_mirror", b_in_ready, b_out_ready);
            if (k == 1) check("b_full_occ", b_occ, 2'd1);
            if (b_in_ready) acc++;
            tick();
        end
        check("b_accepted", acc, 4);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        tick();
        tick();
        check("b_drained", qb.size(), 0);
        check("b_occ_empty", b_occ, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
